uart_alu_cmd_engine: RTL and testbench

Parametrised packet-processing core for the UART ALU. It sits between the UART RX byte stream and the UART TX byte stream.
- Parses framed command packets: 4-byte header followed by little-endian operands.
- Performs a reduction (ADD, SUB, XOR) or an ECHO, then streams the result back out byte by byte.
- Generalises the fixed 32-bit, add-only engine: configurable operand width, arbitrary operand count, multiple opcodes, error accounting.

---
 rtl/uart_alu_cmd_engine_pkg.sv | 25 ++
 rtl/uart_alu_cmd_engine_if.sv | 30 +++
 rtl/uart_alu_cmd_engine_tx_shift.sv | 42 ++++
 rtl/uart_alu_cmd_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_alu_cmd_engine.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_cmd_engine_pkg.sv
// Shared constants and types for the UART ALU command engine: opcodes, header size,
// error response byte and the packet FSM state encoding.
package uart_alu_cmd_engine_pkg;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_SUB  = 8'h5B;
   localparam logic [7:0] OP_XOR  = 8'hE7;

   localparam int unsigned HDR_BYTES     = 4;
   localparam logic [7:0]  ERR_RESP_BYTE = 8'hEE;

   typedef enum logic [2:0] {
      StHdr,
      StPayload,
      StResult,
      StDrain,
      StEresp
   } state_e;

   function automatic logic is_alu_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
   endfunction

endpackage

// File: rtl/uart_alu_cmd_engine_if.sv
// Byte-stream handshake bundle between the UART RX/TX and the command engine.
// The engine uses the slave modport; the UART side (or a bench) uses master.
interface uart_alu_cmd_engine_if;

   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       rx_ready_o;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;

   modport slave (
      input  rx_data_i,
      input  rx_valid_i,
      input  tx_ready_i,
      output rx_ready_o,
      output tx_data_o,
      output tx_valid_o
   );

   modport master (
      output rx_data_i,
      output rx_valid_i,
      output tx_ready_i,
      input  rx_ready_o,
      input  tx_data_o,
      input  tx_valid_o
   );

endinterface

// File: rtl/uart_alu_cmd_engine_tx_shift.sv
// Load-then-shift serializer: takes a DATA_W word plus a byte count and emits the
// bytes LSB first over a valid/ready handshake. o_last flags the final transfer.
module uart_alu_tx_shift #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CNT_W-1:0]  i_nbytes,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_last
);

   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_left;
   logic              r_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shift <= '0;
         r_left  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_left  <= i_nbytes;
         r_valid <= (i_nbytes != '0);
      end else if (r_valid && i_tx_ready) begin
         r_shift <= r_shift >> 8;
         r_left  <= r_left - CNT_W'(1);
         r_valid <= (r_left != CNT_W'(1));
      end
   end

   assign o_tx_data  = r_shift[7:0];
   assign o_tx_valid = r_valid;
   assign o_last     = r_valid && i_tx_ready && (r_left == CNT_W'(1));

endmodule

// File: rtl/uart_alu_cmd_engine.sv
// UART ALU packet engine: parses header+operand packets, reduces them (ADD/SUB/XOR) or
// echoes the payload. Optional macro UART_ALU_ERR_RESP_EN adds an 8'hEE error reply.
module uart_alu_cmd_engine
   import uart_alu_cmd_engine_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   uart_alu_cmd_engine_if.slave bus,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_count_o
);

   localparam int unsigned OP_BYTES = DATA_W / 8;
   localparam int unsigned IDX_W    = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
   localparam int unsigned SH_CNT_W = $clog2(OP_BYTES + 1);

   state_e                r_state, w_state_nxt;
   logic [LEN_W-1:0]      r_cnt;
   logic [LEN_W-1:0]      r_len;
   logic [7:0]            r_len_lo;
   logic [7:0]            r_op;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_first;
   logic [DATA_W-1:0]     r_opnd;
   logic [DATA_W-1:0]     r_acc;
   logic [7:0]            r_echo_data;
   logic                  r_echo_valid;
   logic                  r_err;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   logic                  w_rx_ready;
   logic                  w_rx_fire;
   logic [LEN_W+15:0]     w_len_ext;
   logic [LEN_W-1:0]      w_hdr_len;
   logic [LEN_W-1:0]      w_pay_len;
   logic                  w_len_gt_hdr;
   logic                  w_hdr_ok;
   logic                  w_hdr_last;
   logic                  w_pay_last;
   logic                  w_is_echo;
   logic [DATA_W-1:0]     w_opnd;
   logic                  w_opnd_done;
   logic [DATA_W-1:0]     w_acc_nxt;
   logic                  w_sh_load;
   logic [DATA_W-1:0]     w_sh_data;
   logic [SH_CNT_W-1:0]   w_sh_nbytes;
   logic [7:0]            w_sh_byte;
   logic                  w_sh_valid;
   logic                  w_sh_last;

   assign w_rx_fire = bus.rx_valid_i && w_rx_ready;
   assign w_is_echo = (r_op == OP_ECHO);

   // Upper length bits beyond the two header bytes are always zero.
   assign w_len_ext    = {{LEN_W{1'b0}}, bus.rx_data_i, r_len_lo};
   assign w_hdr_len    = w_len_ext[LEN_W-1:0];
   assign w_pay_len    = w_hdr_len - LEN_W'(HDR_BYTES);
   assign w_len_gt_hdr = (w_hdr_len > LEN_W'(HDR_BYTES));
   assign w_hdr_ok     = w_len_gt_hdr &&
                         (w_is_echo ||
                          (is_alu_op(r_op) && ((w_pay_len % LEN_W'(OP_BYTES)) == '0)));
   assign w_hdr_last   = (r_state == StHdr) && w_rx_fire &&
                         (r_cnt == LEN_W'(HDR_BYTES - 1));
   assign w_pay_last   = (r_cnt == r_len - LEN_W'(1));
   assign w_opnd_done  = (r_idx == IDX_W'(OP_BYTES - 1));

   always_comb begin
      w_opnd = r_opnd;
      w_opnd[{r_idx, 3'b000} +: 8] = bus.rx_data_i;
   end

   always_comb begin
      w_acc_nxt = r_acc;
      if (r_first) begin
         w_acc_nxt = w_opnd;
      end else begin
         case (r_op)
            OP_SUB:  w_acc_nxt = r_acc - w_opnd;
            OP_XOR:  w_acc_nxt = r_acc ^ w_opnd;
            default: w_acc_nxt = r_acc + w_opnd;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rx_ready  = 1'b0;
      w_sh_load   = 1'b0;
      w_sh_data   = w_acc_nxt;
      w_sh_nbytes = SH_CNT_W'(OP_BYTES);
      case (r_state)
         StHdr: begin
            w_rx_ready = 1'b1;
            if (w_hdr_last) begin
               if (w_hdr_ok) begin
                  w_state_nxt = StPayload;
               end else if (w_len_gt_hdr) begin
                  w_state_nxt = StDrain;
               end else begin
`ifdef UART_ALU_ERR_RESP_EN
                  w_state_nxt = StEresp;
                  w_sh_load   = 1'b1;
                  w_sh_data   = DATA_W'(ERR_RESP_BYTE);
                  w_sh_nbytes = SH_CNT_W'(1);
`else
                  w_state_nxt = StHdr;
`endif
               end
            end
         end
         StPayload: begin
            if (w_is_echo) begin
               // Hold off the next packet until the skid register has drained.
               w_rx_ready = (r_cnt != r_len) && (bus.tx_ready_i || !r_echo_valid);
               if ((r_cnt == r_len) && (!r_echo_valid || bus.tx_ready_i)) begin
                  w_state_nxt = StHdr;
               end
            end else begin
               w_rx_ready = 1'b1;
               if (w_rx_fire && w_pay_last) begin
                  w_state_nxt = StResult;
                  w_sh_load   = 1'b1;
               end
            end
         end
         StResult: begin
            if (w_sh_last) begin
               w_state_nxt = StHdr;
            end
         end
         StDrain: begin
            w_rx_ready = 1'b1;
            if (w_rx_fire && w_pay_last) begin
`ifdef UART_ALU_ERR_RESP_EN
               w_state_nxt = StEresp;
               w_sh_load   = 1'b1;
               w_sh_data   = DATA_W'(ERR_RESP_BYTE);
               w_sh_nbytes = SH_CNT_W'(1);
`else
               w_state_nxt = StHdr;
`endif
            end
         end
         StEresp: begin
            if (w_sh_last) begin
               w_state_nxt = StHdr;
            end
         end
         default: w_state_nxt = StHdr;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= StHdr;
         r_cnt        <= '0;
         r_len        <= '0;
         r_len_lo     <= '0;
         r_op         <= '0;
         r_idx        <= '0;
         r_first      <= 1'b0;
         r_opnd       <= '0;
         r_acc        <= '0;
         r_echo_data  <= '0;
         r_echo_valid <= 1'b0;
         r_err        <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= 1'b0;
         if (r_echo_valid && bus.tx_ready_i) begin
            r_echo_valid <= 1'b0;
         end
         if (w_rx_fire) begin
            case (r_state)
               StHdr: begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (r_cnt == LEN_W'(0)) r_op <= bus.rx_data_i;
                  if (r_cnt == LEN_W'(2)) r_len_lo <= bus.rx_data_i;
                  if (w_hdr_last) begin
                     r_len   <= w_hdr_len;
                     r_idx   <= '0;
                     r_first <= 1'b1;
                     if (!w_len_gt_hdr) r_cnt <= '0;
                     if (!w_hdr_ok) begin
                        r_err <= 1'b1;
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                     end
                  end
               end
               StPayload: begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (w_is_echo) begin
                     r_echo_data  <= bus.rx_data_i;
                     r_echo_valid <= 1'b1;
                  end else begin
                     r_opnd <= w_opnd;
                     if (w_opnd_done) begin
                        r_idx   <= '0;
                        r_acc   <= w_acc_nxt;
                        r_first <= 1'b0;
                     end else begin
                        r_idx <= r_idx + IDX_W'(1);
                     end
                  end
               end
               StDrain: r_cnt <= r_cnt + LEN_W'(1);
               default: ;
            endcase
         end
         if ((r_state != StHdr) && (w_state_nxt == StHdr)) begin
            r_cnt <= '0;
         end
      end
   end

   uart_alu_tx_shift #(
      .DATA_W (DATA_W),
      .CNT_W  (SH_CNT_W)
   ) u_tx_shift (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_load     (w_sh_load),
      .i_data     (w_sh_data),
      .i_nbytes   (w_sh_nbytes),
      .o_tx_data  (w_sh_byte),
      .o_tx_valid (w_sh_valid),
      .i_tx_ready (bus.tx_ready_i),
      .o_last     (w_sh_last)
   );

   // Echo skid and serializer are never active together.
   assign bus.tx_valid_o = r_echo_valid | w_sh_valid;
   assign bus.tx_data_o  = r_echo_valid ? r_echo_data : w_sh_byte;
   assign bus.rx_ready_o = w_rx_ready && !rst_i;

   assign busy_o      = (r_state != StHdr) || (r_cnt != '0);
   assign err_o       = r_err;
   assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_uart_alu_cmd_engine.sv
// Self-checking bench for uart_alu_cmd_engine: table of packets with expected TX bytes
// fed through a scoreboard queue, plus hand sequences for back-to-back, reset and saturation.
module tb_uart_alu_cmd_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_alu_cmd_engine_if bus ();
   uart_alu_cmd_engine_if bus_s ();

   logic       busy, err;
   logic [7:0] err_cnt;
   logic       busy_s, err_s;
   logic [1:0] err_cnt_s;

   uart_alu_cmd_engine #(
      .DATA_W    (32),
      .LEN_W     (16),
      .ERR_CNT_W (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .busy_o      (busy),
      .err_o       (err),
      .err_count_o (err_cnt)
   );

   uart_alu_cmd_engine #(
      .DATA_W    (32),
      .LEN_W     (16),
      .ERR_CNT_W (2)
   ) dut_sat (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus_s),
      .busy_o      (busy_s),
      .err_o       (err_s),
      .err_count_o (err_cnt_s)
   );

   assign bus_s.tx_ready_i = 1'b1;

   typedef struct {
      logic [127:0] pkt;
      int           plen;
      logic [63:0]  exp;
      int           elen;
      int           errs;
      bit           bp;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   int          err_pulses = 0;
   bit          bp_mode = 1'b0;
   logic [7:0]  exp_q[$];
   bit          stall_prev = 1'b0;
   logic [7:0]  prev_data = '0;
   vec_t        vecs[14];

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(input logic [127:0] pkt, input int plen,
                               input logic [63:0] exp, input int elen,
                               input int errs, input bit bp);
      vec_t v;
      v.pkt = pkt; v.plen = plen; v.exp = exp; v.elen = elen; v.errs = errs; v.bp = bp;
      return v;
   endfunction

   always @(posedge clk) begin
      #1;
      if (bp_mode) bus.tx_ready_i = ~bus.tx_ready_i;
      else         bus.tx_ready_i = 1'b1;
   end

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_prev) begin
            check("tx_hold_valid", 64'(bus.tx_valid_o), 64'd1);
            check("tx_hold_data", 64'(bus.tx_data_o), 64'(prev_data));
         end
         if (bus.tx_valid_o && bus.tx_ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL tx_unexpected: got %0h want none", bus.tx_data_o);
            end else begin
               check("tx_byte", 64'(bus.tx_data_o), 64'(exp_q.pop_front()));
            end
         end
         stall_prev = bus.tx_valid_o && !bus.tx_ready_i;
         prev_data  = bus.tx_data_o;
         if (err) err_pulses++;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rx_ready_o) begin
         total++;
         bad++;
         $display("FAIL rx_accept_timeout: got ready=0 want ready=1 byte %0h", b);
      end
      @(posedge clk);
      #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic send_pkt(input logic [127:0] pkt, input int plen);
      for (int j = 0; j < plen; j++) send_byte(pkt[8*(plen-1-j) +: 8]);
   endtask

   task automatic push_exp(input logic [63:0] exp, input int elen);
      for (int j = 0; j < elen; j++) exp_q.push_back(exp[8*(elen-1-j) +: 8]);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy || bus.tx_valid_o) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got pending=%0d want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte_s(input logic [7:0] b);
      int n = 0;
      bus_s.rx_data_i  = b;
      bus_s.rx_valid_i = 1'b1;
      @(negedge clk);
      while (!bus_s.rx_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus_s.rx_ready_o) begin
         total++;
         bad++;
         $display("FAIL sat_rx_timeout: got ready=0 want ready=1");
      end
      @(posedge clk);
      #1;
      bus_s.rx_valid_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 64'(bus.rx_ready_o), 64'd0);
      check({tag, "_tx_valid"}, 64'(bus.tx_valid_o), 64'd0);
      check({tag, "_tx_data"}, 64'(bus.tx_data_o), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] ee;
      int          eel;
`ifdef UART_ALU_ERR_RESP_EN
      ee = 64'hEE; eel = 1;
`else
      ee = 64'h0;  eel = 0;
`endif
      vecs[0]  = mk(128'hAD000C00_01000000_02000000, 12, 64'h03000000, 4, 0, 1'b0);
      vecs[1]  = mk(128'hAD000C00_FFFFFFFF_01000000, 12, 64'h00000000, 4, 0, 1'b0);
      vecs[2]  = mk(128'h5B000C00_00000000_01000000, 12, 64'hFFFFFFFF, 4, 0, 1'b0);
      vecs[3]  = mk(128'hEC000700_AA55C3, 7, 64'hAA55C3, 3, 0, 1'b1);
      vecs[4]  = mk(128'hAD000600_1122, 6, ee, eel, 1, 1'b0);
      vecs[5]  = mk(128'hE7000C00_0F000000_F0000000, 12, 64'hFF000000, 4, 1, 1'b0);
      vecs[6]  = mk(128'hAD001000_01000000_02000000_03000000, 16, 64'h06000000, 4, 1, 1'b1);
      vecs[7]  = mk(128'h5B001000_0A000000_03000000_02000000, 16, 64'h05000000, 4, 1, 1'b0);
      vecs[8]  = mk(128'h3C000400, 4, ee, eel, 2, 1'b0);
      vecs[9]  = mk(128'hEC000500_7E, 5, 64'h7E, 1, 2, 1'b1);
      vecs[10] = mk(128'hE7000800_78563412, 8, 64'h78563412, 4, 2, 1'b0);
      vecs[11] = mk(128'hEC000400, 4, ee, eel, 3, 1'b0);
      vecs[12] = mk(128'hAD000A00_112233445566, 10, ee, eel, 4, 1'b1);
      vecs[13] = mk(128'hAD000C00_FF000000_01000000, 12, 64'h00010000, 4, 4, 1'b0);

      bus.rx_valid_i   = 1'b0;
      bus.rx_data_i    = '0;
      bus_s.rx_valid_i = 1'b0;
      bus_s.rx_data_i  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_rx_ready", 64'(bus.rx_ready_o), 64'd1);

      for (int i = 0; i < 14; i++) begin
         bp_mode = vecs[i].bp;
         push_exp(vecs[i].exp, vecs[i].elen);
         send_pkt(vecs[i].pkt, vecs[i].plen);
         wait_idle();
         check($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(vecs[i].errs));
         check($sformatf("vec%0d_err_pulses", i), 64'(err_pulses), 64'(vecs[i].errs));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      end
      bp_mode = 1'b0;

      // Back-to-back packets with no idle gap.
      push_exp(64'h03000000, 4);
      push_exp(64'h02000000, 4);
      send_pkt(128'hAD000C00_01000000_02000000, 12);
      send_pkt(128'h5B000C00_05000000_03000000, 12);
      wait_idle();
      check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a packet.
      send_pkt(128'hAD000C00_01, 5);
      check("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_exp(64'h0C000000, 4);
      send_pkt(128'hAD000C00_05000000_07000000, 12);
      wait_idle();
      check("post_rst_err_cnt", 64'(err_cnt), 64'd0);

      // Saturating error counter on the 2-bit instance.
      for (int k = 1; k <= 5; k++) begin
         int n = 0;
         send_byte_s(8'h3C);
         send_byte_s(8'h00);
         send_byte_s(8'h04);
         send_byte_s(8'h00);
         repeat (2) @(negedge clk);
         while ((bus_s.tx_valid_o || busy_s) && n < 50) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("sat_cnt_%0d", k), 64'(err_cnt_s), 64'((k > 3) ? 3 : k));
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
